// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode, field-position and fetch-state definitions
package cpu_pkg;

   localparam int OPC_MSB = 15;
   localparam int OPC_LSB = 12;
   localparam int RD_MSB  = 11;
   localparam int RD_LSB  = 8;
   localparam int RN_MSB  = 7;
   localparam int RN_LSB  = 4;
   localparam int RM_MSB  = 3;
   localparam int RM_LSB  = 0;

   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_AND  = 4'h2;
   localparam logic [3:0] OP_ORR  = 4'h3;
   localparam logic [3:0] OP_EOR  = 4'h4;
   localparam logic [3:0] OP_LSL  = 4'h5;
   localparam logic [3:0] OP_LSR  = 4'h6;
   localparam logic [3:0] OP_ADDI = 4'h7;
   localparam logic [3:0] OP_SUBI = 4'h8;
   localparam logic [3:0] OP_HALT = 4'h9;
   localparam logic [3:0] OP_MOV  = 4'ha;
   localparam logic [3:0] OP_BL   = 4'hb;
   localparam logic [3:0] OP_BEQ  = 4'hc;
   localparam logic [3:0] OP_BR   = 4'hd;
   localparam logic [3:0] OP_STUR = 4'he;
   localparam logic [3:0] OP_LDUR = 4'hf;

   typedef enum logic {
      FETCH  = 1'b0,
      HALTED = 1'b1
   } fetch_state_t;

endpackage

// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - fetch stage bundle: imem address/data, decode handshake, redirect, status
interface fetch_queue_if #(
   parameter int PC_W    = 4,
   parameter int INSTR_W = 16,
   parameter int DEPTH   = 4
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [PC_W-1:0]    imem_addr;
   logic [INSTR_W-1:0] imem_data;
   logic               out_valid;
   logic               out_ready;
   logic [INSTR_W-1:0] out_instr;
   logic [PC_W-1:0]    out_pc;
   logic               redirect_valid;
   logic [PC_W-1:0]    redirect_pc;
   logic               halted;
   logic [CNT_W-1:0]   count;

   modport master (
      output imem_addr,
      input  imem_data,
      output out_valid,
      input  out_ready,
      output out_instr,
      output out_pc,
      input  redirect_valid,
      input  redirect_pc,
      output halted,
      output count
   );

   modport slave (
      input  imem_addr,
      output imem_data,
      input  out_valid,
      output out_ready,
      input  out_instr,
      input  out_pc,
      output redirect_valid,
      output redirect_pc,
      input  halted,
      input  count
   );
endinterface

// File: rtl/fetch_queue_fifo.sv
// rtl/fetch_queue_fifo.sv - synchronous prefetch FIFO with flush; head read straight from storage
module fetch_fifo #(
   parameter int W     = 20,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       i_push,
   input  logic                       i_pop,
   input  logic                       i_flush,
   input  logic [W-1:0]               i_data,
   output logic [W-1:0]               o_data,
   output logic [$clog2(DEPTH):0]     o_count
);
   localparam int AW    = $clog2(DEPTH);
   localparam int CNT_W = AW + 1;

   logic [W-1:0]     r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CNT_W-1:0] r_count;

   // Storage is cleared on reset so the head reads zero until the first push.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         if (i_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_data  = r_mem[r_rd_ptr];
   assign o_count = r_count;
endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch: owns pc, fills prefetch FIFO, honours redirect and HALT
module fetch_queue
   import cpu_pkg::*;
#(
   parameter int PC_W    = 4,
   parameter int DEPTH   = 4,
   parameter int INSTR_W = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   fetch_queue_if.master bus
);
   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int W     = PC_W + INSTR_W;

   fetch_state_t     r_state;
   fetch_state_t     w_state_nxt;
   logic [PC_W-1:0]  r_pc;
   logic [CNT_W-1:0] w_count;
   logic [W-1:0]     w_head;
   logic             w_valid;
   logic             w_full;
   logic             w_pop;
   logic             w_push;
   logic             w_halt_op;

   assign w_valid   = (w_count != '0);
   assign w_full    = (w_count == CNT_W'(DEPTH));
   // Redirect flushes the queue, so a handshake in that cycle is not a pop.
   assign w_pop     = w_valid & bus.out_ready & ~bus.redirect_valid;
   assign w_push    = ~bus.redirect_valid & (r_state == FETCH) & (~w_full | w_pop);
   assign w_halt_op = (bus.imem_data[OPC_MSB:OPC_LSB] == OP_HALT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc    <= '0;
         r_state <= FETCH;
      end else begin
         r_state <= w_state_nxt;
         if (bus.redirect_valid) r_pc <= bus.redirect_pc;
         else if (w_push)        r_pc <= r_pc + 1'b1;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         FETCH:   if (w_push && w_halt_op) w_state_nxt = HALTED;
         HALTED:  if (bus.redirect_valid)  w_state_nxt = FETCH;
         default: w_state_nxt = FETCH;
      endcase
   end

   fetch_fifo #(
      .W     (W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (bus.redirect_valid),
      .i_data  ({r_pc, bus.imem_data}),
      .o_data  (w_head),
      .o_count (w_count)
   );

   assign bus.imem_addr = r_pc;
   assign bus.out_valid = w_valid;
   assign bus.out_pc    = w_head[W-1:INSTR_W];
   assign bus.out_instr = w_head[INSTR_W-1:0];
   assign bus.count     = w_count;
   assign bus.halted    = (r_state == HALTED);
endmodule
